median_seq_ctrl: RTL and testbench
==================================

MEDIAN_SEQ_CTRL -- requirements
Module: median_seq_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 clk  input  1  Rising-edge clock for all state.
REQ-003 rst  input  1  Synchronous reset, active-high.
REQ-004 start  input  1  Begins a job; accepted only in IDLE.
REQ-005 mode  input  2  Sample count, captured on an accepted start: 01=3, 10=5, 11=7, 00=3.
REQ-006 in_valid  input  1  Sample offered on in_data.
REQ-007 in_data  input  4  Unsigned sample.
REQ-008 in_ready  output  1  High only in LOAD.
REQ-009 out_valid  output  1  Median available; high only in DONE.
REQ-010 out_ready  input  1  Consumer accepts the median.
REQ-011 median  output  4  Median of the job's N samples.
REQ-012 busy  output  1  High in any state other than IDLE.

Function
REQ-013 The FSM SHALL have four states (IDLE, LOAD, SORT, DONE) and no others.
REQ-014 IDLE: start=1 SHALL capture N from mode, clear the sample counter and go to LOAD.
REQ-015 LOAD: each cycle with in_valid&in_ready SHALL write in_data to buffer[count] and increment count.
REQ-016 LOAD: the edge that captures sample N SHALL move the FSM to SORT with pass=0.
REQ-017 SORT SHALL run odd-even transposition sort with one shared compare-swap unit, one compare per cycle, writing min to index j and max to index j+1.
REQ-018 SORT: even passes SHALL compare pairs j=0,2,..,N-3; odd passes SHALL compare pairs j=1,3,..,N-2; there SHALL be N passes.
REQ-019 SORT SHALL last exactly N(N-1)/2 cycles (3/10/21); the last compare's edge SHALL enter DONE.
REQ-020 DONE SHALL drive out_valid=1 and median=buffer[(N-1)/2], holding both stable until out_valid&out_ready.
REQ-021 DONE: out_valid&out_ready SHALL return the FSM to IDLE on that edge; a new start is accepted no earlier than the next cycle.
REQ-022 start outside IDLE SHALL be ignored; mode SHALL be ignored except on an accepted start.
REQ-023 in_valid outside LOAD SHALL be ignored and SHALL NOT alter the buffer.
REQ-024 Comparison SHALL be unsigned 4-bit; equal values SHALL NOT count as a swap.

Reset
REQ-025 rst=1 SHALL force IDLE on the next edge from any state, including mid-LOAD or mid-SORT, discarding the job.
REQ-026 Reset values SHALL be: in_ready=0, out_valid=0, busy=0, median=0, count=0, pass=0.
REQ-027 rst SHALL take priority over start and over both handshakes in the same cycle.

Configuration
REQ-028 With MEDIAN_EARLY_EXIT_EN defined, SORT SHALL enter DONE at the end of any pass once two consecutive completed passes have performed zero swaps.
REQ-029 Without MEDIAN_EARLY_EXIT_EN, SORT SHALL always run all N passes (REQ-019) and the swap-tracking logic SHALL be absent.

Structure
REQ-030 Package median_pkg SHALL hold DATA_W=4, MAX_N=7, the mode encodings and the FSM state enum.
REQ-031 Compare-swap SHALL be one combinational sub-module, cmp_swap (inputs a, b; outputs lo, hi, swapped), instantiated exactly once.
REQ-032 The buffer SHALL be MAX_N x DATA_W registers, indexed by the pair counter.

Verification
REQ-033 mode=01, samples 5,9,1, out_ready=1 -> out_valid 3 edges after the 3rd capture, median=5, FSM back in IDLE the next cycle.
REQ-034 mode=11, samples 15,0,7,7,3,12,8 -> SORT lasts 21 cycles, median=7.
REQ-035 mode=10, samples 4,4,4,4,4 -> median=4; SORT lasts 10 cycles without the macro, 4 cycles with MEDIAN_EARLY_EXIT_EN.
REQ-036 In DONE with median=6, hold out_ready=0 for 5 cycles and pulse start -> out_valid and median=6 stay stable, start ignored, busy=1.
REQ-037 Assert rst in SORT cycle 4 of a mode=11 job -> next cycle IDLE with busy=0, in_ready=0, out_valid=0; a new mode=01 job (2,8,3) then returns median=3.
REQ-038 mode=00, samples 14,2,9 -> treated as N=3, median=9; in_valid pulses in IDLE/SORT leave the result unchanged.

Source files
------------

// File: rtl/median_seq_ctrl_pkg.sv
// Shared types and constants for the sequential median engine: data width,
// buffer depth, mode encodings and the controller state enum.
package median_pkg;

    localparam int DATA_W = 4;
    localparam int MAX_N  = 7;

    localparam logic [1:0] MODE_N3_ALT = 2'b00;
    localparam logic [1:0] MODE_N3     = 2'b01;
    localparam logic [1:0] MODE_N5     = 2'b10;
    localparam logic [1:0] MODE_N7     = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SORT,
        ST_DONE
    } state_t;

    function automatic logic [2:0] n_from_mode(input logic [1:0] m);
        case (m)
            MODE_N5: return 3'd5;
            MODE_N7: return 3'd7;
            default: return 3'd3;
        endcase
    endfunction

endpackage

// File: rtl/median_seq_ctrl_cmp_swap.sv
// Single unsigned compare-swap cell shared by every step of the sort.
// Equal operands are left in place and do not report a swap.
module cmp_swap
    import median_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] lo,
    output logic [DATA_W-1:0] hi,
    output logic              swapped
);

    assign swapped = (a > b);
    assign lo      = swapped ? b : a;
    assign hi      = swapped ? a : b;

endmodule

// File: rtl/median_seq_ctrl.sv
// Sequential median of 3/5/7 unsigned samples using odd-even transposition
// sort on one compare-swap cell. Define MEDIAN_EARLY_EXIT_EN to stop sorting
// once two consecutive passes finish without a swap.
module median_seq_ctrl
    import median_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] median,
    output logic              busy
);

    state_t            r_state;
    logic [2:0]        r_n;
    logic [2:0]        r_cnt;
    logic [2:0]        r_pass;
    logic [2:0]        r_j;
    logic              r_in_ready;
    logic              r_out_valid;
    logic              r_busy;
    logic [DATA_W-1:0] r_median;
    logic [DATA_W-1:0] r_buf [MAX_N];

    logic [DATA_W-1:0] w_lo;
    logic [DATA_W-1:0] w_hi;
    logic              w_swapped;
    logic [DATA_W-1:0] w_nxt [MAX_N];
    logic [2:0]        w_last_j;
    logic [2:0]        w_mid;
    logic              w_pass_end;
    logic              w_last_pass;
    logic              w_early;

    cmp_swap u_cmp_swap (
        .a       (r_buf[r_j]),
        .b       (r_buf[r_j + 3'd1]),
        .lo      (w_lo),
        .hi      (w_hi),
        .swapped (w_swapped)
    );

    // Buffer contents as they will be after this cycle's compare-swap.
    always_comb begin
        w_nxt = r_buf;
        w_nxt[r_j]        = w_lo;
        w_nxt[r_j + 3'd1] = w_hi;
    end

    assign w_last_j    = r_pass[0] ? (r_n - 3'd2) : (r_n - 3'd3);
    assign w_mid       = (r_n - 3'd1) >> 1;
    assign w_pass_end  = (r_j == w_last_j);
    assign w_last_pass = (r_pass == r_n - 3'd1);

`ifdef MEDIAN_EARLY_EXIT_EN
    logic r_pass_swp;
    logic r_prev_clean;
    logic w_clean;

    assign w_clean = ~(r_pass_swp | w_swapped);
    assign w_early = w_clean & r_prev_clean;
`else
    assign w_early = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_n         <= 3'd3;
            r_cnt       <= 3'd0;
            r_pass      <= 3'd0;
            r_j         <= 3'd0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_median    <= '0;
`ifdef MEDIAN_EARLY_EXIT_EN
            r_pass_swp   <= 1'b0;
            r_prev_clean <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_n        <= n_from_mode(mode);
                        r_cnt      <= 3'd0;
                        r_state    <= ST_LOAD;
                        r_in_ready <= 1'b1;
                        r_busy     <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (in_valid) begin
                        r_buf[r_cnt] <= in_data;
                        r_cnt        <= r_cnt + 3'd1;
                        if (r_cnt == r_n - 3'd1) begin
                            r_state    <= ST_SORT;
                            r_in_ready <= 1'b0;
                            r_pass     <= 3'd0;
                            r_j        <= 3'd0;
`ifdef MEDIAN_EARLY_EXIT_EN
                            r_pass_swp   <= 1'b0;
                            r_prev_clean <= 1'b0;
`endif
                        end
                    end
                end
                ST_SORT: begin
                    if (w_swapped) begin
                        r_buf <= w_nxt;
                    end
                    if (w_pass_end) begin
                        if (w_last_pass || w_early) begin
                            r_state     <= ST_DONE;
                            r_out_valid <= 1'b1;
                            r_median    <= w_nxt[w_mid];
                        end else begin
                            r_pass <= r_pass + 3'd1;
                            r_j    <= r_pass[0] ? 3'd0 : 3'd1;
                        end
`ifdef MEDIAN_EARLY_EXIT_EN
                        r_pass_swp   <= 1'b0;
                        r_prev_clean <= w_clean;
`endif
                    end else begin
                        r_j <= r_j + 3'd2;
`ifdef MEDIAN_EARLY_EXIT_EN
                        r_pass_swp <= r_pass_swp | w_swapped;
`endif
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state     <= ST_IDLE;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign median    = r_median;

endmodule

// File: tb/tb_median_seq_ctrl.sv
// Testbench for median_seq_ctrl: table of jobs driven through a scoreboard,
// plus hand-written hold and mid-sort reset sequences.
module tb_median_seq_ctrl;

    typedef struct packed {
        logic [1:0]      mode;
        logic [2:0]      n;
        logic [6:0][3:0] samp;
        logic [3:0]      med;
        logic            noise;
    } vec_t;

    logic       clk;
    logic       rst;
    logic       start;
    logic [1:0] mode;
    logic       in_valid;
    logic [3:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] median;
    logic       busy;

    int checks;
    int failures;
    logic [3:0] sb_q[$];
    vec_t vecs[6];

    median_seq_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .median    (median),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] m, input int n,
                                input int s0, input int s1, input int s2, input int s3,
                                input int s4, input int s5, input int s6,
                                input int med, input logic noise);
        vec_t v;
        v.mode    = m;
        v.n       = 3'(n);
        v.samp[0] = 4'(s0);
        v.samp[1] = 4'(s1);
        v.samp[2] = 4'(s2);
        v.samp[3] = 4'(s3);
        v.samp[4] = 4'(s4);
        v.samp[5] = 4'(s5);
        v.samp[6] = 4'(s6);
        v.med     = 4'(med);
        v.noise   = noise;
        return v;
    endfunction

    // Reference odd-even transposition sort, counting compare cycles.
    function automatic int model_len(input vec_t v);
        logic [3:0] a[7];
        logic [3:0] t;
        int cyc;
`ifdef MEDIAN_EARLY_EXIT_EN
        bit sw;
        bit prev_clean;
        prev_clean = 1'b0;
`endif
        cyc = 0;
        for (int i = 0; i < 7; i++) a[i] = v.samp[i];
        for (int p = 0; p < int'(v.n); p++) begin
`ifdef MEDIAN_EARLY_EXIT_EN
            sw = 1'b0;
`endif
            for (int j = p % 2; j + 1 < int'(v.n); j += 2) begin
                cyc++;
                if (a[j] > a[j+1]) begin
                    t      = a[j];
                    a[j]   = a[j+1];
                    a[j+1] = t;
`ifdef MEDIAN_EARLY_EXIT_EN
                    sw = 1'b1;
`endif
                end
            end
`ifdef MEDIAN_EARLY_EXIT_EN
            if (!sw && prev_clean) return cyc;
            prev_clean = !sw;
`endif
        end
        return cyc;
    endfunction

    task automatic run_job(input vec_t v, input int hold);
        int k;
        int exp_len;
        logic [3:0] exp_med;
        exp_len = model_len(v);
        if (v.noise) begin
            in_valid = 1'b1;
            in_data  = 4'd0;
            tick();
            in_valid = 1'b0;
        end
        chk("idle_busy", {7'd0, busy}, 8'd0);
        start = 1'b1;
        mode  = v.mode;
        sb_q.push_back(v.med);
        tick();
        start = 1'b0;
        mode  = 2'b11;
        chk("load_in_ready", {7'd0, in_ready}, 8'd1);
        chk("load_busy", {7'd0, busy}, 8'd1);
        for (int i = 0; i < int'(v.n); i++) begin
            if (v.noise && i == 1) begin
                in_valid = 1'b0;
                in_data  = 4'd15;
                tick();
            end
            in_valid = 1'b1;
            in_data  = v.samp[i];
            tick();
        end
        in_valid = 1'b0;
        in_data  = 4'd0;
        chk("sort_in_ready", {7'd0, in_ready}, 8'd0);
        out_ready = (hold == 0);
        k = 0;
        while (!out_valid && k < 100) begin
            if (v.noise) begin
                in_valid = 1'b1;
                in_data  = 4'd15;
            end
            tick();
            k++;
        end
        in_valid = 1'b0;
        if (!out_valid) begin
            chk("done_timeout", 8'd0, 8'd1);
            return;
        end
        chk("sort_len", 8'(k), 8'(exp_len));
        exp_med = sb_q.pop_front();
        chk("median", {4'd0, median}, {4'd0, exp_med});
        for (int c = 0; c < hold; c++) begin
            start = (c == 2);
            mode  = 2'b11;
            tick();
            start = 1'b0;
            chk("hold_valid", {7'd0, out_valid}, 8'd1);
            chk("hold_median", {4'd0, median}, {4'd0, exp_med});
            chk("hold_busy", {7'd0, busy}, 8'd1);
        end
        out_ready = 1'b1;
        tick();
        chk("ret_busy", {7'd0, busy}, 8'd0);
        chk("ret_out_valid", {7'd0, out_valid}, 8'd0);
        chk("ret_in_ready", {7'd0, in_ready}, 8'd0);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        start     = 1'b0;
        mode      = 2'b00;
        in_valid  = 1'b0;
        in_data   = 4'd0;
        out_ready = 1'b1;

        vecs[0] = mk(2'b01, 3,  5, 9, 1, 0, 0, 0, 0, 5, 1'b0);
        vecs[1] = mk(2'b11, 7, 15, 0, 7, 7, 3, 12, 8, 7, 1'b0);
        vecs[2] = mk(2'b10, 5,  4, 4, 4, 4, 4, 0, 0, 4, 1'b0);
        vecs[3] = mk(2'b00, 3, 14, 2, 9, 0, 0, 0, 0, 9, 1'b1);
        vecs[4] = mk(2'b10, 5,  9, 1, 6, 13, 6, 0, 0, 6, 1'b1);
        vecs[5] = mk(2'b11, 7, 15, 13, 11, 9, 7, 5, 3, 9, 1'b0);

        tick();
        tick();
        rst = 1'b0;
        chk("rst_in_ready", {7'd0, in_ready}, 8'd0);
        chk("rst_out_valid", {7'd0, out_valid}, 8'd0);
        chk("rst_busy", {7'd0, busy}, 8'd0);
        chk("rst_median", {4'd0, median}, 8'd0);

        for (int i = 0; i < 6; i++) run_job(vecs[i], 0);

        // Median 6 held in DONE for 5 cycles with a start pulse.
        run_job(mk(2'b01, 3, 6, 2, 9, 0, 0, 0, 0, 6, 1'b0), 5);

        // Reset during SORT cycle 4 of a 7-sample job, with start also high.
        start = 1'b1;
        mode  = 2'b11;
        tick();
        start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1;
            in_data  = vecs[1].samp[i];
            tick();
        end
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        chk("midsort_busy", {7'd0, busy}, 8'd1);
        rst   = 1'b1;
        start = 1'b1;
        tick();
        rst   = 1'b0;
        start = 1'b0;
        chk("rst_sort_busy", {7'd0, busy}, 8'd0);
        chk("rst_sort_in_ready", {7'd0, in_ready}, 8'd0);
        chk("rst_sort_out_valid", {7'd0, out_valid}, 8'd0);
        chk("rst_sort_median", {4'd0, median}, 8'd0);
        tick();
        chk("rst_sort_stay_idle", {7'd0, busy}, 8'd0);

        run_job(mk(2'b01, 3, 2, 8, 3, 0, 0, 0, 0, 3, 1'b0), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
